// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: opcode/output-state types and helpers shared by the spi_ram_stream files
package spi_ram_pkg;

    localparam int OPC_W = 2;

    typedef enum logic [OPC_W-1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_st_e;

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_ram_array.sv
// spi_ram_array: DEPTH x DATA_W storage, one synchronous write port and one synchronous read port, no reset
module spi_ram_array #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) q <= mem[raddr];
    end

endmodule

// File: rtl/spi_ram_stream.sv
// spi_ram_stream: command-decoded RAM behind the SPI slave; SPI_RAM_BURST_EN enables pointer auto-increment
module spi_ram_stream
    import spi_ram_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int ADDR_W = 8,
    parameter  int DEPTH  = 256,
    localparam int PW     = max_w(ADDR_W, DATA_W)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx_valid,
    input  logic [PW+OPC_W-1:0] din,
    output logic                rx_ready,
    output logic [DATA_W-1:0]   dout,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                addr_err
);

    localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    cmd_e              op;
    logic [ADDR_W-1:0] pay_a;
    logic [DATA_W-1:0] pay_d;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [DATA_W-1:0] q;
    logic              acc;
    logic              oob;
    logic              we;
    logic              re;
    logic              loaded;
    out_st_e           st;

    assign op       = cmd_e'(din[PW+OPC_W-1:PW]);
    assign pay_a    = din[ADDR_W-1:0];
    assign pay_d    = din[DATA_W-1:0];
    assign tx_valid = (st == OUT_FULL);
    assign rx_ready = !tx_valid || tx_ready;
    assign acc      = rx_valid && rx_ready;
    assign oob      = {1'b0, pay_a} >= DEPTH_V;
    assign we       = acc && (op == CMD_WR_DATA);
    assign re       = acc && (op == CMD_RD_DATA);
    // the array's read register carries no reset, so dout reads 0 until the first read after reset
    assign dout     = loaded ? q : '0;

    function automatic logic [ADDR_W-1:0] inc(input logic [ADDR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    spi_ram_array #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) u_array (
        .clk  (clk),
        .we   (we),
        .waddr(wr_ptr),
        .wdata(pay_d),
        .re   (re),
        .raddr(rd_ptr),
        .q    (q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            st       <= OUT_EMPTY;
            addr_err <= 1'b0;
            loaded   <= 1'b0;
        end else begin
            addr_err <= acc && (op == CMD_WR_ADDR || op == CMD_RD_ADDR) && oob;
            if (acc && op == CMD_WR_ADDR && !oob) wr_ptr <= pay_a;
`ifdef SPI_RAM_BURST_EN
            else if (we) wr_ptr <= inc(wr_ptr);
`endif
            if (acc && op == CMD_RD_ADDR && !oob) rd_ptr <= pay_a;
`ifdef SPI_RAM_BURST_EN
            else if (re) rd_ptr <= inc(rd_ptr);
`endif
            if (re) loaded <= 1'b1;
            // a new read refills; otherwise a consumed word empties the register
            st <= re ? OUT_FULL : (tx_ready ? OUT_EMPTY : st);
        end
    end

`ifndef SPI_RAM_BURST_EN
    logic unused_inc;
    assign unused_inc = ^inc(wr_ptr);
`endif

endmodule

// File: doc/spi_ram_stream.md
Name: spi_ram_stream

Overview:
Parametrised command-driven single-port-array RAM sitting behind the SPI slave. It decodes 2-bit-opcode command words from the SPI receive path and manages separate write and read address pointers. Successor features:
- configurable data/address width and depth
- optional address auto-increment for burst transfers
- valid/ready backpressure on the read-data return path
- out-of-range address detection

Parameters:
DATA_W, 8, memory word width and dout width
ADDR_W, 8, address pointer width
DEPTH, 256, number of words; legal range 2..2**ADDR_W
PW (localparam), max(ADDR_W, DATA_W), payload width of a command word

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
rx_valid  in  1  command word on din is valid
din  in  PW+2  din[PW+1:PW] = opcode, din[PW-1:0] = payload
rx_ready  out  1  block can accept a command this cycle
dout  out  DATA_W  read data
tx_valid  out  1  dout holds unconsumed read data
tx_ready  in  1  downstream (SPI transmit) consumes dout
addr_err  out  1  one-cycle pulse: address command rejected

Behaviour:
- Reset, asynchronous: wr_ptr=0, rd_ptr=0, dout=0, tx_valid=0, addr_err=0. Memory array is not reset; contents are undefined until written.
- Accept: a command is accepted on a rising edge where rx_valid && rx_ready.
- rx_ready = !tx_valid || tx_ready (combinational). Any command is stalled while read data is pending and not being consumed.
- Opcodes:
  - 00 WR_ADDR: wr_ptr <= din[ADDR_W-1:0]
  - 01 WR_DATA: mem[wr_ptr] <= din[DATA_W-1:0]
  - 10 RD_ADDR: rd_ptr <= din[ADDR_W-1:0]
  - 11 RD_DATA: dout <= mem[rd_ptr]; tx_valid <= 1
- Unused upper payload bits are ignored.
- Address range check: WR_ADDR/RD_ADDR with payload >= DEPTH leaves the pointer unchanged. addr_err is 1 for exactly the cycle after acceptance and 0 otherwise.
- RD_DATA latency: dout and tx_valid are valid the cycle after acceptance.
- Output register FSM, two states:
  - EMPTY (tx_valid=0): moves to FULL on an accepted RD_DATA.
  - FULL (tx_valid=1): tx_ready=1 without a new RD_DATA goes to EMPTY; tx_ready=1 with an accepted RD_DATA reloads dout and stays FULL; tx_ready=0 holds dout and tx_valid stable.
- One RD_DATA per cycle sustains full throughput when tx_ready stays high.
- Read-after-write: WR_DATA at edge N followed by RD_DATA to the same address at edge N+1 or later returns the new value.
- Single port: only one command per cycle, so there is no same-cycle read/write conflict.
- dout is not cleared when tx_valid falls; it retains the last value.
- Reset mid-operation: all registers clear immediately, with no wait for clk. A pending tx_valid is dropped.

Optional Feature:
Macro SPI_RAM_BURST_EN.
- Defined: after WR_DATA, wr_ptr <= wr_ptr+1; after RD_DATA, rd_ptr <= rd_ptr+1. A pointer equal to DEPTH-1 wraps to 0. Increment never raises addr_err.
- Undefined: pointers change only on WR_ADDR/RD_ADDR (legacy single-word behaviour).

Decomposition:
- Package spi_ram_pkg:
  - opcode enum cmd_e: CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11
  - output-state enum out_st_e: OUT_EMPTY, OUT_FULL
  - opcode field width constant OPC_W=2
- Sub-module spi_ram_array: DEPTH x DATA_W storage with one synchronous write port and one synchronous read port, no reset. Top level holds decode, pointers, range check and the output FSM.

Test Plan (defaults unless stated; din is 10 bits):
1. Basic write/read: rst pulse; WR_ADDR 0x10; WR_DATA 0xA5; RD_ADDR 0x10; RD_DATA with tx_ready=1 -> next cycle dout=0xA5, tx_valid=1 for one cycle, addr_err never set.
2. Burst with wrap (BURST_EN): WR_ADDR 0xFF; WR_DATA 0x11, 0x22; RD_ADDR 0xFF; RD_DATA x2 back-to-back, tx_ready=1 -> dout 0x11 then 0x22 on consecutive cycles, confirming mem[0x00]=0x22.
3. Backpressure: hold tx_ready=0 after RD_DATA -> tx_valid=1 and dout held, rx_ready=0, a WR_ADDR presented is not taken. Raise tx_ready -> tx_valid falls next cycle, then WR_ADDR is accepted.
4. Range check (DEPTH=200 instance): WR_ADDR 0xC8 -> addr_err one-cycle pulse; following WR_DATA 0x5A lands at the previous wr_ptr. RD_ADDR 0xC7 -> no error.
5. Reset mid-operation: assert rst asynchronously while tx_valid=1, dout=0x3C -> tx_valid=0, dout=0 before the next clk edge; pointers read back as 0.
6. Legacy mode (macro undefined): WR_ADDR 0x05; WR_DATA 0x01, 0x02; read 0x05 -> 0x02; read 0x06 -> not 0x01 (address 0x06 untouched).
